// File: rtl/sd_emmc_cmd_rx.sv
// SD/eMMC CMD-line response receiver: waits for the start bit, shifts in a 48- or
// 136-bit response, checks CRC7 and framing, and reports it with a one-cycle valid pulse.
module sd_emmc_cmd_rx #(
   parameter int TIMEOUT_W = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 smp_en_i,
   input  logic                 cmd_i,
   input  logic                 start_i,
   input  logic                 long_i,
   input  logic                 crc_chk_i,
   input  logic                 abort_i,
   input  logic [TIMEOUT_W-1:0] timeout_i,
   output logic                 busy_o,
   output logic                 valid_o,
   output logic [5:0]           index_o,
   output logic [127:0]         resp_o,
   output logic                 crc_err_o,
   output logic                 frame_err_o,
   output logic                 timeout_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RECV = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
      logic fb;
      fb = crc[6] ^ din;
      crc7_step = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
   endfunction

   state_t               r_state;
   logic                 r_long;
   logic                 r_crc_chk;
   logic [TIMEOUT_W-1:0] r_wait_cnt;
   logic [7:0]           r_bit_cnt;
   logic [133:0]         r_shift;
   logic [6:0]           r_crc;
   logic                 r_busy;
   logic                 r_valid;
   logic                 r_timeout;
   logic [5:0]           r_index;
   logic [127:0]         r_resp;
   logic                 r_crc_err;
   logic                 r_frame_err;

   // The start bit is always 0, so only frame bits 134..0 are kept.
   logic [134:0]         w_frame;
   logic [7:0]           w_next_cnt;
   logic [7:0]           w_last_cnt;
   logic                 w_is_end;
   logic                 w_crc_en;
   logic [6:0]           w_crc_next;
   logic [TIMEOUT_W-1:0] w_wait_inc;
   logic                 w_timeout_hit;
   logic [5:0]           w_index_end;
   logic [127:0]         w_resp_end;
   logic                 w_crc_err_end;
   logic                 w_frame_err_end;

   assign w_frame     = {r_shift, cmd_i};
   assign w_next_cnt  = r_bit_cnt + 8'd1;
   assign w_last_cnt  = r_long ? 8'd136 : 8'd48;
   assign w_is_end    = (w_next_cnt == w_last_cnt);
   // R2 excludes its 8 header bits from the CRC; R1-style frames include the start bit.
   assign w_crc_en    = r_long ? ((w_next_cnt >= 8'd9) && (w_next_cnt <= 8'd128))
                               : (w_next_cnt <= 8'd40);
   assign w_crc_next  = crc7_step(r_crc, cmd_i);

   assign w_wait_inc    = (r_wait_cnt == {TIMEOUT_W{1'b1}}) ? r_wait_cnt
                        : r_wait_cnt + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
   assign w_timeout_hit = (timeout_i != {TIMEOUT_W{1'b0}}) && (w_wait_inc >= timeout_i);

   assign w_index_end     = r_long ? w_frame[133:128] : w_frame[45:40];
   assign w_resp_end      = r_long ? {w_frame[127:1], 1'b0} : {96'd0, w_frame[39:8]};
   assign w_crc_err_end   = r_crc_chk & (r_crc != w_frame[7:1]);
   assign w_frame_err_end = (r_long ? w_frame[134] : w_frame[46]) | ~w_frame[0];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= ST_IDLE;
         r_long      <= 1'b0;
         r_crc_chk   <= 1'b0;
         r_wait_cnt  <= {TIMEOUT_W{1'b0}};
         r_bit_cnt   <= 8'd0;
         r_shift     <= 134'd0;
         r_crc       <= 7'd0;
         r_busy      <= 1'b0;
         r_valid     <= 1'b0;
         r_timeout   <= 1'b0;
         r_index     <= 6'd0;
         r_resp      <= 128'd0;
         r_crc_err   <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_valid   <= 1'b0;
         r_timeout <= 1'b0;
         if (abort_i) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (start_i) begin
                     r_state    <= ST_WAIT;
                     r_busy     <= 1'b1;
                     r_wait_cnt <= {TIMEOUT_W{1'b0}};
                     r_long     <= long_i;
                     r_crc_chk  <= crc_chk_i;
                  end
               end
               ST_WAIT: begin
                  if (smp_en_i) begin
                     if (!cmd_i) begin
                        r_state   <= ST_RECV;
                        r_bit_cnt <= 8'd1;
                        r_shift   <= 134'd0;
                        r_crc     <= crc7_step(7'd0, 1'b0);
                     end else begin
                        r_wait_cnt <= w_wait_inc;
                        if (w_timeout_hit) begin
                           r_timeout <= 1'b1;
                           r_busy    <= 1'b0;
                           r_state   <= ST_IDLE;
                        end
                     end
                  end
               end
               ST_RECV: begin
                  if (smp_en_i) begin
                     r_shift   <= w_frame[133:0];
                     r_bit_cnt <= w_next_cnt;
                     if (w_crc_en) begin
                        r_crc <= w_crc_next;
                     end
                     if (w_is_end) begin
                        r_state     <= ST_DONE;
                        r_valid     <= 1'b1;
                        r_busy      <= 1'b0;
                        r_index     <= w_index_end;
                        r_resp      <= w_resp_end;
                        r_crc_err   <= w_crc_err_end;
                        r_frame_err <= w_frame_err_end;
                     end
                  end
               end
               ST_DONE: begin
                  r_state <= ST_IDLE;
               end
               default: begin
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign busy_o      = r_busy;
   assign valid_o     = r_valid;
   assign timeout_o   = r_timeout;
   assign index_o     = r_index;
   assign resp_o      = r_resp;
   assign crc_err_o   = r_crc_err;
   assign frame_err_o = r_frame_err;

endmodule

// File: doc/sd_emmc_cmd_rx.md
# sd_emmc_cmd_rx

Receive side of the SD/eMMC CMD line. Once armed after a command is transmitted, it samples the CMD pad input once per SD clock strobe, detects the response start bit, and shifts in a 48-bit or 136-bit response. It checks CRC7 and framing, then presents the response to the command engine with a single-cycle valid pulse. It is the input-direction counterpart of the pad output buffer and sits between the CMD input buffer and the controller's command FSM.

## Interface
- TIMEOUT_W, 16: width of the start-bit timeout counter and of `timeout_i`.
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- smp_en_i  in  1  one-cycle sample strobe at the SD clock rising edge; `cmd_i` is sampled only when this is high.
- cmd_i  in  1  CMD line after the input buffer; idle high.
- start_i  in  1  arm pulse that starts waiting for a response.
- long_i  in  1  response length; 0 selects 48-bit (R1/R3/R6/R7), 1 selects 136-bit (R2). Captured at `start_i`.
- crc_chk_i  in  1  enables the CRC7 check (0 for R3). Captured at `start_i`.
- abort_i  in  1  returns the block to IDLE immediately; no pulses are emitted.
- timeout_i  in  TIMEOUT_W  maximum number of strobes to wait for the start bit; 0 means no timeout.
- busy_o  out  1  high while armed or receiving.
- valid_o  out  1  one-cycle pulse when a complete response has been captured.
- index_o  out  6  response index field; holds the header bits for R2.
- resp_o  out  128  response payload.
- crc_err_o  out  1  CRC7 mismatch; qualified by `valid_o` and held afterwards.
- frame_err_o  out  1  transmission bit was not 0 or end bit was not 1; qualified by `valid_o` and held.
- timeout_o  out  1  one-cycle pulse when no start bit arrived within the timeout.

## Operation
- States are IDLE, WAIT, RECV and DONE.
- IDLE:
  - `start_i` moves to WAIT, clears the wait counter and captures `long_i` and `crc_chk_i`.
  - `start_i` is ignored in every other state.
- WAIT, on each strobe:
  - `cmd_i`=0: this is the start bit. Move to RECV with bit count 1 and feed 0 into the CRC.
  - `cmd_i`=1: increment the wait counter. If `timeout_i`≠0 and the counter reaches `timeout_i`, pulse `timeout_o` and go to IDLE.
- RECV: shift `cmd_i` in MSB-first on each strobe. The frame is N=48 or N=136 bits including the start bit.
- CRC7 uses polynomial x^7+x^3+1 with initial value 0.
  - 48-bit frames: the CRC covers frame bits 47..8, i.e. start, transmission, index and argument.
  - 136-bit frames: the CRC covers frame bits 127..8 and excludes the 8 header bits.
- When the strobe samples the end bit (bit count N), move to DONE.
- DONE lasts one cycle:
  - pulse `valid_o` and update `index_o`, `resp_o`, `crc_err_o` and `frame_err_o`;
  - then go to IDLE.
- Output mapping, 48-bit: `index_o`=frame[45:40]; `resp_o`[31:0]=frame[39:8]; `resp_o`[127:32]=0.
- Output mapping, 136-bit: `index_o`=frame[133:128] (expected 6'h3F); `resp_o`[127:1]=frame[127:1], which includes the CRC at [7:1]; `resp_o`[0]=0.
- `crc_err_o` = `crc_chk_i` AND (computed CRC ≠ received frame[7:1]).
- `frame_err_o` = (frame[N-2]≠0) OR (frame[0]≠1).
- `abort_i` in any state moves to IDLE. `index_o`, `resp_o` and both error flags keep their previous values.
- `abort_i` and `start_i` in the same cycle: abort wins, and the state is IDLE on the next cycle.
- Reset: state is IDLE and all outputs are 0.

## Timing
- `busy_o` rises the cycle after `start_i`. It falls in the cycle `valid_o` or `timeout_o` is high, or the cycle after `abort_i`.
- `valid_o` rises exactly one `clk_i` cycle after the strobe that samples the end bit.
- The data outputs change only in that `valid_o` cycle and hold until the next `valid_o`.
- `timeout_o` rises one cycle after the strobe on which the counter reaches `timeout_i`. Data outputs do not change on a timeout.
- A new `start_i` is accepted in the first IDLE cycle after `valid_o` or `timeout_o`.
- Strobes may be back-to-back (`smp_en_i` held high). The block then receives one bit per `clk_i`.
- A reset asserted mid-frame discards the partial frame. No pulse is emitted.
- The wait counter saturates and does not wrap when `timeout_i`=0.

## Test plan
- **R7:** arm with long_i=0, crc_chk_i=1. Drive frame 0x08000001AA13 with strobes every 4 clocks. Expect `valid_o` 1 cycle after the last strobe, `index_o`=8, `resp_o`=0x1AA, `crc_err_o`=0, `frame_err_o`=0.
- **CRC error:** same frame with argument bit 0 flipped (…01AB13). Expect `valid_o` with `crc_err_o`=1 and `resp_o`=0x1AB.
- **R3:** frame 0x3F80FF8000FF with crc_chk_i=0. Expect `index_o`=0x3F, `resp_o`=0x80FF8000, `crc_err_o`=0. Then set the end bit to 0 and expect `frame_err_o`=1.
- **R2:** 136-bit frame with header 0x3F, a 120-bit pattern and a bench-computed CRC. Expect `resp_o`[127:1] to match and `crc_err_o`=0, using back-to-back strobes.
- **Timeout:** `timeout_i`=64 with `cmd_i` held high. Expect `timeout_o` exactly once, 1 cycle after the 64th strobe, `busy_o` to fall, and outputs unchanged.
- **Reset and abort:** assert `rst_i` after 20 bits, then `abort_i` after 20 bits of a second frame. Expect no `valid_o`, `busy_o`=0, and the next R7 frame received correctly.
